// File: rtl/dma_desc_sched.sv
// Descriptor-chain DMA scheduler: fetches 4-word descriptors one read at a time,
// issues each transfer to the datapath and walks the next-pointer chain.
module dma_desc_sched #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_go_i,
  input  logic             ctrl_stop_i,
  input  logic [31:0]      desc_ptr_i,
  output logic             mem_rd_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_wait_rq_i,
  input  logic [31:0]      mem_rd_data_i,
  input  logic             mem_rd_valid_i,
  output logic             xfer_start_o,
  output logic [31:0]      xfer_src_o,
  output logic [31:0]      xfer_dst_o,
  output logic [LEN_W-1:0] xfer_len_o,
  input  logic             xfer_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [CNT_W-1:0] desc_count_o,
  output logic [31:0]      cur_desc_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_ISSUE, S_WAIT_DONE, S_NEXT
  } state_t;

  state_t           r_state;
  logic             r_go_q;
  logic [1:0]       r_idx;
  logic [31:0]      r_src, r_dst, r_next, r_cur;
  logic [LEN_W-1:0] r_len;
  logic             r_bad;
  logic             r_mem_rd, r_xfer_start, r_done, r_error;
  logic [31:0]      r_mem_addr, r_xfer_src, r_xfer_dst;
  logic [LEN_W-1:0] r_xfer_len;
  logic [CNT_W-1:0] r_count;

  logic             w_go_edge;
  logic [1:0]       w_idx_inc;
  logic [31:0]      w_next_word_addr;
  logic             w_bad;

  assign w_go_edge        = ctrl_go_i & ~r_go_q;
  assign w_idx_inc        = r_idx + 2'd1;
  assign w_next_word_addr = r_cur + {28'd0, w_idx_inc, 2'b00};
  // Evaluated when the last word arrives; src/dst/len were captured earlier.
  assign w_bad = (r_len == '0) | (|r_src[1:0]) | (|r_dst[1:0]) | (|r_cur[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      // Resets high so a go already asserted at reset release is not seen as an edge.
      r_go_q       <= 1'b1;
      r_idx        <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_next       <= '0;
      r_cur        <= '0;
      r_bad        <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_xfer_start <= 1'b0;
      r_xfer_src   <= '0;
      r_xfer_dst   <= '0;
      r_xfer_len   <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_count      <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch sees
      // the pre-edge values, regardless of statement order.
      r_go_q <= ctrl_go_i;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go_edge) begin
            r_cur      <= desc_ptr_i;
            r_count    <= '0;
            r_error    <= 1'b0;
            r_idx      <= '0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= desc_ptr_i;
            r_state    <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (!mem_wait_rq_i) begin
            r_mem_rd <= 1'b0;
            r_state  <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_rd_valid_i) begin
            case (r_idx)
              2'd0:    r_src  <= mem_rd_data_i;
              2'd1:    r_dst  <= mem_rd_data_i;
              2'd2:    r_len  <= mem_rd_data_i[LEN_W-1:0];
              default: r_next <= mem_rd_data_i;
            endcase
            if (r_idx != 2'd3) begin
              r_idx      <= w_idx_inc;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_next_word_addr;
              r_state    <= S_RD_REQ;
            end else begin
              r_bad <= w_bad;
              if (!w_bad) begin
                r_xfer_start <= 1'b1;
                r_xfer_src   <= r_src;
                r_xfer_dst   <= r_dst;
                r_xfer_len   <= r_len;
              end
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_xfer_start <= 1'b0;
          if (r_bad) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (xfer_done_i) begin
            if (r_count != '1) r_count <= r_count + CNT_W'(1);
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (ctrl_stop_i || (r_next == '0)) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cur      <= r_next;
            r_idx      <= '0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_next;
            r_state    <= S_RD_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_o     = r_mem_rd;
  assign mem_addr_o   = r_mem_addr;
  assign xfer_start_o = r_xfer_start;
  assign xfer_src_o   = r_xfer_src;
  assign xfer_dst_o   = r_xfer_dst;
  assign xfer_len_o   = r_xfer_len;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = r_done;
  assign error_o      = r_error;
  assign desc_count_o = r_count;
  assign cur_desc_o   = r_cur;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed bench for dma_desc_sched: memory and datapath responders plus
// hand-computed expectations for single, chained, error, stop and reset cases.
module tb_dma_desc_sched;
  localparam int LEN_W = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             ctrl_go_i = 1'b0;
  logic             ctrl_stop_i = 1'b0;
  logic [31:0]      desc_ptr_i = '0;
  logic             mem_rd_o;
  logic [31:0]      mem_addr_o;
  logic             mem_wait_rq_i = 1'b0;
  logic [31:0]      mem_rd_data_i = '0;
  logic             mem_rd_valid_i = 1'b0;
  logic             xfer_start_o;
  logic [31:0]      xfer_src_o, xfer_dst_o;
  logic [LEN_W-1:0] xfer_len_o;
  logic             xfer_done_i = 1'b0;
  logic             busy_o, done_o, error_o;
  logic [CNT_W-1:0] desc_count_o;
  logic [31:0]      cur_desc_o;

  dma_desc_sched #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .ctrl_go_i(ctrl_go_i), .ctrl_stop_i(ctrl_stop_i), .desc_ptr_i(desc_ptr_i),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_wait_rq_i(mem_wait_rq_i),
    .mem_rd_data_i(mem_rd_data_i), .mem_rd_valid_i(mem_rd_valid_i),
    .xfer_start_o(xfer_start_o), .xfer_src_o(xfer_src_o), .xfer_dst_o(xfer_dst_o),
    .xfer_len_o(xfer_len_o), .xfer_done_i(xfer_done_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .desc_count_o(desc_count_o), .cur_desc_o(cur_desc_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory image indexed by word address bits [9:2].
  logic [31:0] mem [0:255];

  int          nreads, nstarts, ndone, addr_moves;
  logic [31:0] rd_addr [0:15];
  logic [31:0] st_src, st_dst;
  logic [15:0] st_len;
  int          stall_cfg = 0, stall_left = 0, dp_lat = 4, dp_cnt = 0;
  bit          auto_done = 1'b1, req_active = 1'b0, resp_pending = 1'b0;
  bit          stray_req = 1'b0, manual_done = 1'b0;
  logic [31:0] req_addr, pend_addr;

  // Memory/datapath responder and monitor; acts on the falling edge.
  initial forever begin
    @(negedge clk);
    mem_rd_valid_i = 1'b0;
    xfer_done_i    = 1'b0;
    if (resp_pending) begin
      mem_rd_valid_i = 1'b1;
      mem_rd_data_i  = mem[pend_addr[9:2]];
      resp_pending   = 1'b0;
    end else if (stray_req) begin
      mem_rd_valid_i = 1'b1;
      mem_rd_data_i  = 32'hDEAD_BEEF;
      stray_req      = 1'b0;
    end
    if (mem_rd_o && !req_active) begin
      req_active = 1'b1;
      stall_left = stall_cfg;
      req_addr   = mem_addr_o;
      if (nreads < 16) rd_addr[nreads] = mem_addr_o;
      nreads++;
    end
    if (req_active) begin
      if (mem_addr_o !== req_addr || !mem_rd_o) addr_moves++;
      if (stall_left > 0) begin
        mem_wait_rq_i = 1'b1;
        stall_left--;
      end else begin
        mem_wait_rq_i = 1'b0;
        resp_pending  = 1'b1;
        pend_addr     = req_addr;
        req_active    = 1'b0;
      end
    end else begin
      mem_wait_rq_i = 1'b0;
    end
    if (dp_cnt > 0) begin
      dp_cnt--;
      if (dp_cnt == 0) xfer_done_i = 1'b1;
    end
    if (manual_done) begin
      xfer_done_i = 1'b1;
      manual_done = 1'b0;
    end
    if (xfer_start_o) begin
      nstarts++;
      st_src = xfer_src_o;
      st_dst = xfer_dst_o;
      st_len = xfer_len_o;
      if (auto_done) dp_cnt = dp_lat;
    end
    if (done_o) ndone++;
  end

  task automatic clear_log();
    nreads = 0; nstarts = 0; ndone = 0; addr_moves = 0;
    req_active = 1'b0; resp_pending = 1'b0; dp_cnt = 0;
    st_src = '0; st_dst = '0; st_len = '0;
    for (int i = 0; i < 16; i++) rd_addr[i] = '0;
  endtask

  task automatic pulse_go();
    @(negedge clk); ctrl_go_i = 1'b1;
    @(negedge clk); ctrl_go_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n >= 500), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (nstarts == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_timeout"}, 32'(n >= 500), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h1000; mem[8'h41] = 32'h2000; mem[8'h42] = 32'd64; mem[8'h43] = 32'h0;
    mem[8'h80] = 32'h3000; mem[8'h81] = 32'h4000; mem[8'h82] = 32'h20; mem[8'h83] = 32'h0;
    mem[8'hC0] = 32'h1000; mem[8'hC1] = 32'h2000; mem[8'hC2] = 32'h0;  mem[8'hC3] = 32'h0;
    mem[8'hE0] = 32'h5000; mem[8'hE1] = 32'h6000; mem[8'hE2] = 32'h10; mem[8'hE3] = 32'h0;
    clear_log();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_error", 32'(error_o), 0);
    check("rst_mem_rd", 32'(mem_rd_o), 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_xfer_start", 32'(xfer_start_o), 0);
    check("rst_xfer_src", xfer_src_o, 0);
    check("rst_xfer_len", 32'(xfer_len_o), 0);
    check("rst_count", 32'(desc_count_o), 0);
    check("rst_cur", cur_desc_o, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single descriptor, no stalls
    desc_ptr_i = 32'h100; stall_cfg = 0; dp_lat = 4; auto_done = 1'b1;
    clear_log();
    pulse_go();
    wait_idle("t1");
    check("t1_nreads", 32'(nreads), 4);
    check("t1_addr0", rd_addr[0], 32'h100);
    check("t1_addr1", rd_addr[1], 32'h104);
    check("t1_addr2", rd_addr[2], 32'h108);
    check("t1_addr3", rd_addr[3], 32'h10C);
    check("t1_nstarts", 32'(nstarts), 1);
    check("t1_src", st_src, 32'h1000);
    check("t1_dst", st_dst, 32'h2000);
    check("t1_len", 32'(st_len), 64);
    check("t1_ndone", 32'(ndone), 1);
    check("t1_count", 32'(desc_count_o), 1);
    check("t1_error", 32'(error_o), 0);

    // Two-descriptor chain with 3-cycle stall on every read
    mem[8'h43] = 32'h200; stall_cfg = 3;
    clear_log();
    pulse_go();
    wait_idle("t2");
    check("t2_nreads", 32'(nreads), 8);
    check("t2_addr4", rd_addr[4], 32'h200);
    check("t2_addr7", rd_addr[7], 32'h20C);
    check("t2_addr_stable", 32'(addr_moves), 0);
    check("t2_nstarts", 32'(nstarts), 2);
    check("t2_last_src", st_src, 32'h3000);
    check("t2_count", 32'(desc_count_o), 2);
    check("t2_ndone", 32'(ndone), 1);

    // Zero-length descriptor
    desc_ptr_i = 32'h300; stall_cfg = 0;
    clear_log();
    pulse_go();
    wait_idle("t3");
    check("t3_error", 32'(error_o), 1);
    check("t3_nstarts", 32'(nstarts), 0);
    check("t3_busy", 32'(busy_o), 0);
    check("t3_ndone", 32'(ndone), 0);
    check("t3_nreads", 32'(nreads), 4);

    // Stop during first transfer of a 3-descriptor chain
    mem[8'h83] = 32'h380; desc_ptr_i = 32'h100; dp_lat = 6;
    clear_log();
    pulse_go();
    wait_start("t4");
    ctrl_stop_i = 1'b1;
    wait_idle("t4");
    ctrl_stop_i = 1'b0;
    check("t4_nstarts", 32'(nstarts), 1);
    check("t4_count", 32'(desc_count_o), 1);
    check("t4_ndone", 32'(ndone), 1);
    check("t4_nreads", 32'(nreads), 4);
    check("t4_error", 32'(error_o), 0);

    // Asynchronous reset while waiting for transfer completion
    mem[8'h83] = 32'h0; mem[8'h43] = 32'h0; auto_done = 1'b0;
    clear_log();
    pulse_go();
    wait_start("t5");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_busy_async", 32'(busy_o), 0);
    check("t5_cur_async", cur_desc_o, 0);
    check("t5_src_async", xfer_src_o, 0);
    check("t5_count_async", 32'(desc_count_o), 0);
    ctrl_go_i = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    nr = nreads;
    manual_done = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_busy_after", 32'(busy_o), 0);
    check("t5_count_after", 32'(desc_count_o), 0);
    check("t5_no_done", 32'(ndone), 0);
    check("t5_go_held_noread", 32'(nreads - nr), 0);
    ctrl_go_i = 1'b0;
    repeat (2) @(negedge clk);
    desc_ptr_i = 32'h200; auto_done = 1'b1;
    clear_log();
    pulse_go();
    wait_idle("t5b");
    check("t5_restart_addr", rd_addr[0], 32'h200);
    check("t5_restart_src", st_src, 32'h3000);
    check("t5_restart_count", 32'(desc_count_o), 1);
    check("t5_restart_done", 32'(ndone), 1);

    // Stray read-valid in IDLE, then go re-pulsed while busy
    desc_ptr_i = 32'h100; dp_lat = 10;
    clear_log();
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_stray_busy", 32'(busy_o), 0);
    check("t6_stray_reads", 32'(nreads), 0);
    pulse_go();
    repeat (2) @(negedge clk);
    pulse_go();
    pulse_go();
    wait_idle("t6");
    check("t6_nreads", 32'(nreads), 4);
    check("t6_nstarts", 32'(nstarts), 1);
    check("t6_ndone", 32'(ndone), 1);
    check("t6_count", 32'(desc_count_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
